psd_pattern_gen: RTL and testbench

//  Programmable serial pattern transmitter, the send side of the programmable sequence detector link.
//  On a start request it latches a WIDTH-bit pattern, a repeat count and a gap length.
//  It then shifts the pattern out one bit per clock, repeating it with optional idle gaps.

---
 rtl/psd_pattern_gen.sv | 135 +++++++++++++
 tb/tb_psd_pattern_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/psd_pattern_gen.sv
// Programmable serial pattern transmitter: latches a pattern, repeat count and gap on start,
// then streams the pattern MSB-index-first with optional idle gaps between repetitions.
module psd_pattern_gen #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [0:WIDTH-1]   init,
    input  logic [CNT_W-1:0]   reps,
    input  logic [GAP_W-1:0]   gap,
    input  logic               abort,
    output logic               dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [0:WIDTH-1]   pat_q, pat_d;
    logic [CNT_W-1:0]   reps_q, reps_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            reps_q  <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            idx_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            reps_q  <= reps_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        reps_d  = reps_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort && (reps != '0)) begin
                    state_d = S_SEND;
                    pat_d   = init;
                    reps_d  = reps;
                    gap_d   = gap;
                    idx_d   = '0;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_q == LAST_IDX) begin
                    // reps_q holds the repetitions still owed, including the current one
                    idx_d = '0;
                    if (reps_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        reps_d = reps_q - CNT_W'(1);
                        if (gap_q != '0) begin
                            state_d = S_GAP;
                            gcnt_d  = gap_q;
                        end
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gcnt_q == GAP_W'(1)) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered: derive them from the state being entered
        valid_d = (state_d == S_SEND);
        dout_d  = valid_d & pat_d[idx_d];
        busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_psd_pattern_gen.sv
// Directed bench for psd_pattern_gen: inputs change on the falling edge, outputs checked there.
module tb_psd_pattern_gen;

    localparam int WIDTH = 5;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic               clk = 1'b0;
    logic               resetn;
    logic               start;
    logic [0:WIDTH-1]   init;
    logic [CNT_W-1:0]   reps;
    logic [GAP_W-1:0]   gap;
    logic               abort;
    logic               dout;
    logic               dout_valid;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psd_pattern_gen #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .init(init),
        .reps(reps),
        .gap(gap),
        .abort(abort),
        .dout(dout),
        .dout_valid(dout_valid),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic outs(input string tag, input logic v, input logic d, input logic b, input logic dn);
        chk({tag, "_valid"}, dout_valid, v);
        chk({tag, "_dout"},  dout, d);
        chk({tag, "_busy"},  busy, b);
        chk({tag, "_done"},  done, dn);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bits(input string tag, input logic [0:WIDTH-1] p);
        for (int i = 0; i < WIDTH; i++) begin
            outs($sformatf("%s_b%0d", tag, i), 1'b1, p[i], 1'b1, 1'b0);
            step();
        end
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            outs($sformatf("%s_i%0d", tag, i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    initial begin
        logic [0:WIDTH-1] p;

        // Test 1a: reset held with start asserted
        resetn = 1'b0;
        start  = 1'b1;
        init   = 5'b11011;
        reps   = 8'd1;
        gap    = 4'd0;
        abort  = 1'b0;
        @(negedge clk);
        outs("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        outs("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        outs("rst2", 1'b0, 1'b0, 1'b0, 1'b0);
        start  = 1'b0;
        resetn = 1'b1;
        step();
        outs("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 2: single rep, no gap
        p     = 5'b11011;
        init  = p;
        reps  = 8'd1;
        gap   = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits("t2", p);
        outs("t2_done", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle_cycles("t2_post", 2);

        // Test 3: two reps with a 3-cycle gap
        p     = 5'b10110;
        init  = p;
        reps  = 8'd2;
        gap   = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits("t3r0", p);
        for (int i = 0; i < 3; i++) begin
            outs($sformatf("t3_gap%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
            step();
        end
        send_bits("t3r1", p);
        outs("t3_done", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle_cycles("t3_post", 1);

        // Test 4: three back-to-back reps, init changed mid-transfer
        p     = 5'b11011;
        init  = p;
        reps  = 8'd3;
        gap   = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            outs($sformatf("t4_b%0d", i), 1'b1, p[i % WIDTH], 1'b1, 1'b0);
            if (i == 1) begin
                init = 5'b00100;
                reps = 8'd1;
                gap  = 4'd7;
            end
            step();
        end
        outs("t4_done", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle_cycles("t4_post", 1);

        // Test 5: abort at c3, restart at c5
        p     = 5'b11011;
        init  = p;
        reps  = 8'd1;
        gap   = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        outs("t5_c1", 1'b1, p[0], 1'b1, 1'b0);
        step();
        outs("t5_c2", 1'b1, p[1], 1'b1, 1'b0);
        step();
        outs("t5_c3", 1'b1, p[2], 1'b1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        outs("t5_c4", 1'b0, 1'b0, 1'b0, 1'b0);
        p     = 5'b10110;
        init  = p;
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits("t5_re", p);
        outs("t5_done", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle_cycles("t5_post", 1);

        // Test 5b: abort together with start in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        idle_cycles("t5_abst", 2);

        // Test 6: reps==0 is ignored
        reps  = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        idle_cycles("t6_r0", 3);

        // Test 6b: start pulses during SEND and on the DONE cycle are ignored
        p     = 5'b11011;
        init  = p;
        reps  = 8'd1;
        gap   = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            outs($sformatf("t6_b%0d", i), 1'b1, p[i], 1'b1, 1'b0);
            start = (i == 1);
            reps  = (i == 1) ? 8'd2 : 8'd1;
            step();
        end
        start = 1'b0;
        outs("t6_done", 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        idle_cycles("t6_post", 3);

        // Test 1b: asynchronous reset during GAP
        p     = 5'b10110;
        init  = p;
        reps  = 8'd2;
        gap   = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        send_bits("t1b", p);
        outs("t1b_gap", 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        resetn = 1'b0;
        #1;
        outs("t1b_async", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        idle_cycles("t1b_post", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
